// File: rtl/counter_share_arb_if.sv
// rtl/counter_share_arb_if.sv - request/grant/counter bundle between clients and counter_share_arb
interface counter_share_arb_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] limit;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [CNT_W-1:0]       count_out;
  logic [N_REQ-1:0]       done;

  modport master (output req, limit, input gnt, busy, count_out, done);
  modport slave  (input req, limit, output gnt, busy, count_out, done);
endinterface

// File: rtl/counter_share_arb.sv
// rtl/counter_share_arb.sv - round-robin time-sharing of one up-counter; COUNTER_SHARE_ARB_GRAY_EN selects Gray-coded count_out
module counter_share_arb #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           reset,
  counter_share_arb_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    next_ptr;
  logic             own_req;
  logic             at_limit;
  logic [CNT_W-1:0] lim_slice [N_REQ];

  // Unpack the flat limit bus so the winner's slice can be picked by index
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      lim_slice[i] = bus.limit[i*CNT_W +: CNT_W];
    end
  end

  assign own_req  = bus.req[win_q];
  assign at_limit = (cnt_q == lim_q);
  assign next_ptr = (int'(win_q) == N_REQ - 1) ? '0 : win_q + PW'(1);

  // Round-robin search: first requesting line at or after ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % N_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: arbitrate in IDLE, run to the captured limit, abort on dropped request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = RUN;
      RUN: begin
        if (!own_req)      state_d = IDLE;
        else if (at_limit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: winner/limit capture, counting, pointer advance past the winner
  always_comb begin
    ptr_d = ptr_q;
    win_d = win_q;
    lim_d = lim_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          win_d = win_idx;
          lim_d = lim_slice[win_idx];
        end
      end
      RUN: begin
        if (!own_req) begin
          cnt_d = '0;
          ptr_d = next_ptr;
        end else if (!at_limit) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d = '0;
        ptr_d = next_ptr;
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      win_q <= '0;
      lim_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      win_q <= win_d;
      lim_q <= lim_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs decoded from state and the held winner index
  always_comb begin
    bus.gnt  = '0;
    bus.done = '0;
    bus.busy = 1'b0;
    if (state_q != IDLE) begin
      bus.gnt[win_q] = 1'b1;
      bus.busy       = 1'b1;
    end
    if (state_q == DONE) begin
      bus.done[win_q] = 1'b1;
    end
  end

`ifdef COUNTER_SHARE_ARB_GRAY_EN
  logic [CNT_W-1:0] gray_q;

  // Registered Gray image of the binary count; terminal compare stays on cnt_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_q <= '0;
    end else begin
      gray_q <= cnt_d ^ (cnt_d >> 1);
    end
  end

  assign bus.count_out = gray_q;
`else
  assign bus.count_out = cnt_q;
`endif
endmodule
